// File: rtl/debounce_bank.sv
// N-channel push-button conditioner: 2-flop sync, symmetric debounce, press/release strobes
// and optional auto-repeat while a key is held.
module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int DEB_LIMIT     = 65535,
  parameter int REPEAT_DELAY  = 1000000,
  parameter int REPEAT_PERIOD = 250000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int DCW  = $clog2(DEB_LIMIT + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);

  localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEB_LIMIT - 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic [N_CH-1:0] s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [DCW-1:0] dcnt;
    logic [RCW-1:0] rcnt;
    logic           first;
    logic           level, press, release_s, rpt;
    logic           flip, active, rep_hit;

    always_comb begin
      flip    = (s2[ch] != level) && (dcnt == DEB_LAST);
      active  = level && repeat_en[ch];
      rep_hit = active && (first ? (rcnt == DELAY_LAST) : (rcnt == PERIOD_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt      <= '0;
        rcnt      <= '0;
        first     <= 1'b1;
        level     <= 1'b0;
        press     <= 1'b0;
        release_s <= 1'b0;
        rpt       <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_s <= 1'b0;

        if (s2[ch] == level) begin
          dcnt <= '0;
        end else if (flip) begin
          dcnt      <= '0;
          level     <= s2[ch];
          press     <= s2[ch];
          release_s <= ~s2[ch];
        end else begin
          dcnt <= dcnt + DCW'(1);
        end

        // The press edge itself counts as rcnt=0 so the first repeat lands REPEAT_DELAY later.
        if (!active || (flip && s2[ch])) begin
          rcnt  <= '0;
          first <= 1'b1;
        end else if (rep_hit) begin
          rcnt  <= '0;
          first <= 1'b0;
        end else begin
          rcnt <= rcnt + RCW'(1);
        end

        rpt <= rep_hit && !flip;
      end
    end

    assign btn_level[ch]   = level;
    assign btn_press[ch]   = press;
    assign btn_release[ch] = release_s;
    assign btn_repeat[ch]  = rpt;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus randomized bouncing input,
// all cycles checked against a timestamp-based reference model.
module tb_debounce_bank;

  localparam int N      = 4;
  localparam int DEB    = 8;
  localparam int DELAY  = 20;
  localparam int PERIOD = 5;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_in, repeat_en;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  debounce_bank #(
    .N_CH(N), .DEB_LIMIT(DEB), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a key flips after DEB consecutive synchronised samples disagreeing with it;
  // repeats fire at anchor+DELAY+k*PERIOD, the anchor being the press or last non-active cycle.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;
  int m_run[N];
  int m_anchor[N];
  int m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      m_press = '0; m_rel = '0; m_rep = '0;
      m_cyc = 0;
      for (int ch = 0; ch < N; ch++) begin
        m_run[ch] = 0;
        m_anchor[ch] = 0;
      end
    end else begin
      m_cyc = m_cyc + 1;
      for (int ch = 0; ch < N; ch++) begin
        bit samp, act, flip;
        samp = m_s2[ch];
        act  = m_level[ch] && repeat_en[ch];
        flip = 1'b0;
        m_press[ch] = 1'b0; m_rel[ch] = 1'b0; m_rep[ch] = 1'b0;
        if (samp != m_level[ch]) begin
          m_run[ch] = m_run[ch] + 1;
          if (m_run[ch] == DEB) begin
            flip = 1'b1;
            m_run[ch] = 0;
            m_level[ch] = samp;
            m_press[ch] = samp;
            m_rel[ch] = !samp;
          end
        end else begin
          m_run[ch] = 0;
        end
        if (act && !flip && (m_cyc - m_anchor[ch] >= DELAY) &&
            ((m_cyc - m_anchor[ch] - DELAY) % PERIOD == 0))
          m_rep[ch] = 1'b1;
        if (!act || (flip && samp)) m_anchor[ch] = m_cyc;
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  wire [4*N-1:0] dut_v = {btn_level, btn_press, btn_release, btn_repeat};
  wire [4*N-1:0] mod_v = {m_level, m_press, m_rel, m_rep};

  task automatic test_reset();
    btn_in = '1;
    rst_n  = 1'b0;
    #1;
    chk_cnt++;
    if (dut_v !== '0) $display("FAIL reset_async dut=%h exp=0", dut_v); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (dut_v !== '0) $display("FAIL reset_hold dut=%h exp=0", dut_v); else pass_cnt++;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL reset_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      chk_cnt++;
      if (btn_level !== ((k >= 10) ? 4'hF : 4'h0) || btn_press !== ((k == 10) ? 4'hF : 4'h0))
        $display("FAIL reset_exit k=%0d level=%h press=%h exp_level=%h exp_press=%h",
                 k, btn_level, btn_press, (k >= 10) ? 4'hF : 4'h0, (k == 10) ? 4'hF : 4'h0);
      else pass_cnt++;
    end
    btn_in = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL release_all k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    int presses, at;
    presses = 0; at = 0;
    for (int i = 0; i < 5; i++) begin
      btn_in[0] = (i == 0 || i == 2 || i == 3);
      @(negedge clk);
      if (btn_press[0]) presses++;
    end
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL bounce_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      if (btn_press[0]) begin presses++; at = k; end
    end
    chk_cnt++;
    if (presses != 1 || at != 10)
      $display("FAIL bounce_press count=%0d at=%0d exp count=1 at=10", presses, at);
    else pass_cnt++;
  endtask

  task automatic test_repeat();
    int got, seen, nrep;
    int offs[$];
    got = 0; seen = 0;
    repeat_en[1] = 1'b1;
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (btn_press[1]) seen = 1;
    end
    chk_cnt++;
    if (!seen) $display("FAIL repeat_press_timeout seen=0 exp=1"); else pass_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL repeat_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      if (btn_repeat[1]) offs.push_back(k);
    end
    nrep = offs.size();
    chk_cnt++;
    if (nrep != 5) $display("FAIL repeat_count got=%0d exp=5", nrep); else pass_cnt++;
    for (int i = 0; i < nrep && i < 5; i++) begin
      chk_cnt++;
      if (offs[i] != DELAY + i * PERIOD)
        $display("FAIL repeat_time idx=%0d got=%0d exp=%0d", i, offs[i], DELAY + i * PERIOD);
      else pass_cnt++;
    end
    got = nrep;
  endtask

  task automatic test_no_repeat();
    int reps, seen;
    reps = 0; seen = 0;
    repeat_en[2] = 1'b0;
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (btn_press[2]) seen = 1;
    end
    chk_cnt++;
    if (!seen) $display("FAIL norep_press_timeout seen=0 exp=1"); else pass_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL norep_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      if (btn_repeat[2]) reps++;
    end
    chk_cnt++;
    if (reps != 0) $display("FAIL norep_count got=%0d exp=0", reps); else pass_cnt++;
  endtask

  task automatic test_release();
    int at, cnt;
    at = 0; cnt = 0;
    btn_in[2] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL release_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      if (btn_release[2]) begin cnt++; at = k; end
    end
    chk_cnt++;
    if (cnt != 1 || at != 10 || btn_level[2] !== 1'b0)
      $display("FAIL release_edge count=%0d at=%0d level=%b exp count=1 at=10 level=0",
               cnt, at, btn_level[2]);
    else pass_cnt++;
  endtask

  task automatic test_reset_midcount();
    btn_in[3] = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (dut_v !== '0) $display("FAIL midreset_async dut=%h exp=0", dut_v); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL midreset_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      chk_cnt++;
      if (btn_level[3] !== (k >= 10))
        $display("FAIL midreset_level3 k=%0d got=%b exp=%b", k, btn_level[3], (k >= 10));
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    btn_in[3] = 1'b0;
    repeat (7) @(negedge clk);
    btn_in[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL glitch_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      if (btn_level[3] !== 1'b1 || btn_press[3] || btn_release[3]) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL glitch_ch3 bad_cycles=%0d exp=0", bad); else pass_cnt++;
  endtask

  task automatic test_aligned();
    int kp, kr;
    kp = 0; kr = 0;
    btn_in[0] = 1'b0;
    repeat (14) @(negedge clk);
    btn_in[0] = 1'b1;
    btn_in[3] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL aligned_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
      if (btn_press[0]) kp = k;
      if (btn_release[3]) kr = k;
    end
    chk_cnt++;
    if (kp != 10 || kr != 10)
      $display("FAIL aligned_strobes press_at=%0d release_at=%0d exp both=10", kp, kr);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int hold[N];
    for (int ch = 0; ch < N; ch++) hold[ch] = 0;
    for (int k = 1; k <= 1500; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          btn_in[ch] = $urandom_range(0, 1);
          hold[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 60);
        end else begin
          hold[ch]--;
        end
      end
      if ($urandom_range(0, 99) == 0) repeat_en = 4'($urandom);
      @(negedge clk);
      chk_cnt++;
      if (dut_v !== mod_v) $display("FAIL random_model k=%0d dut=%h exp=%h", k, dut_v, mod_v);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    btn_in = '0;
    repeat_en = '0;
    #1;
    test_reset();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_release();
    test_reset_midcount();
    test_glitch();
    test_aligned();
    repeat_en = 4'b1011;
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
